// File: rtl/pipe_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipe_ctrl                                                  |
// | Description : Central pipeline sequencer for the 5-stage core. Detects   |
// |               ID/EX load-use hazards, sequences the shared fixed-latency |
// |               iterative divider on behalf of EX, drives the per-stage    |
// |               stall vector and flush pulse, and keeps a saturating       |
// |               stall-cycle counter for performance monitoring.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Parameters                                                               |
// |   DIV_LAT : cycles from div_start to a valid divider result (>= 2)       |
// |   CNT_W   : width of the stall-cycle counter                             |
// | Ports                                                                    |
// |   clk                  rising-edge clock                                 |
// |   rst                  synchronous, active-high reset                    |
// |   id_reg1_read_i/addr  ID source operand 1 read enable / register        |
// |   id_reg2_read_i/addr  ID source operand 2 read enable / register        |
// |   ex_is_load_i         EX instruction is a load                          |
// |   ex_wd_i / ex_wreg_i  EX destination register / write enable            |
// |   ex_div_req_i         EX holds a div/divu needing the divider           |
// |   ex_div_signed_i      1 = div, 0 = divu                                 |
// |   flush_req_i          exception/redirect: kill in-flight work           |
// |   div_start_o          1-cycle pulse: divider latches operands           |
// |   div_signed_o         signedness captured at div_start                  |
// |   div_cancel_o         1-cycle pulse: divider aborts                     |
// |   div_done_o           1-cycle pulse: EX captures divider result         |
// |   stall_o[5:0]         [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB; 1 = hold    |
// |   flush_o              clear all pipeline registers this cycle           |
// |   stall_cycles_o       cycles with stall != 0, saturating                |
// +--------------------------------------------------------------------------+
module pipe_ctrl #(
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_reg1_read_i,
  input  logic [4:0]       id_reg1_addr_i,
  input  logic             id_reg2_read_i,
  input  logic [4:0]       id_reg2_addr_i,
  input  logic             ex_is_load_i,
  input  logic [4:0]       ex_wd_i,
  input  logic             ex_wreg_i,
  input  logic             ex_div_req_i,
  input  logic             ex_div_signed_i,
  input  logic             flush_req_i,
  output logic             div_start_o,
  output logic             div_signed_o,
  output logic             div_cancel_o,
  output logic             div_done_o,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  // Countdown only ever holds DIV_LAT-1 down to 1, so clog2 bits suffice.
  localparam int            CW       = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_LAT - 1);
  localparam logic [5:0]    STALL_DIV = 6'b001111;
  localparam logic [5:0]    STALL_LU  = 6'b000111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_signed_q, div_signed_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  // High for the first cycle after reset; all outputs stay quiet then.
  logic             first_q;

  logic             active;
  logic             hazard;
  logic             start;
  logic [5:0]       stall;
  logic             flush;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      div_signed_q   <= 1'b0;
      stall_cycles_q <= '0;
      first_q        <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      div_signed_q   <= div_signed_d;
      stall_cycles_q <= stall_cycles_d;
      first_q        <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    div_signed_d   = div_signed_q;
    stall_cycles_d = stall_cycles_q;
    stall          = 6'b000000;
    flush          = 1'b0;
    start          = 1'b0;
    div_cancel_o   = 1'b0;
    div_done_o     = 1'b0;

    // Gating on rst as well as first_q keeps the combinational outputs at
    // zero while reset is asserted, whatever the sideband inputs are doing.
    active = !rst && !first_q;

    // $0 is hardwired to zero, so it can never carry a load-use dependence.
    hazard = ex_is_load_i && ex_wreg_i && (ex_wd_i != 5'd0) &&
             ((id_reg1_read_i && (id_reg1_addr_i == ex_wd_i)) ||
              (id_reg2_read_i && (id_reg2_addr_i == ex_wd_i)));

    if (active) begin
      if (flush_req_i) begin
        flush = 1'b1;
        if (state_q != IDLE) begin
          div_cancel_o = 1'b1;
          state_d      = IDLE;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (ex_div_req_i) begin
              start        = 1'b1;
              div_signed_d = ex_div_signed_i;
              cnt_d        = CNT_LOAD;
              state_d      = BUSY;
            end
          end
          BUSY: begin
            // Leaving when the decremented count hits zero places DONE
            // exactly DIV_LAT cycles after the start pulse.
            cnt_d = cnt_q - CW'(1);
            if (cnt_d == '0) begin
              state_d = DONE;
            end
          end
          DONE: begin
            div_done_o = 1'b1;
            state_d    = IDLE;
          end
          default: begin
            state_d = IDLE;
          end
        endcase

        if (start || (state_q == BUSY)) begin
          stall = STALL_DIV;
        end else if (state_q == DONE) begin
          // EX must advance to take the result, so nothing is held here.
          stall = 6'b000000;
        end else if (hazard) begin
          stall = STALL_LU;
        end
      end
    end

    if ((stall != 6'b000000) && !flush && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  assign div_start_o    = start;
  assign div_signed_o   = div_signed_q;
  assign stall_o        = stall;
  assign flush_o        = flush;
  assign stall_cycles_o = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pipe_ctrl                                               |
// | Description : Self-checking bench for pipe_ctrl: directed vectors with   |
// |               literal expectations plus a per-cycle behavioural model.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pipe_ctrl;

  localparam int DIV_LAT = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_reg1_read, id_reg2_read;
  logic [4:0]       id_reg1_addr, id_reg2_addr;
  logic             ex_is_load, ex_wreg, ex_div_req, ex_div_signed, flush_req;
  logic [4:0]       ex_wd;
  logic             div_start, div_signed, div_cancel, div_done, flush;
  logic [5:0]       stall;
  logic [CNT_W-1:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_ctrl #(.DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_reg1_read_i  (id_reg1_read),
    .id_reg1_addr_i  (id_reg1_addr),
    .id_reg2_read_i  (id_reg2_read),
    .id_reg2_addr_i  (id_reg2_addr),
    .ex_is_load_i    (ex_is_load),
    .ex_wd_i         (ex_wd),
    .ex_wreg_i       (ex_wreg),
    .ex_div_req_i    (ex_div_req),
    .ex_div_signed_i (ex_div_signed),
    .flush_req_i     (flush_req),
    .div_start_o     (div_start),
    .div_signed_o    (div_signed),
    .div_cancel_o    (div_cancel),
    .div_done_o      (div_done),
    .stall_o         (stall),
    .flush_o         (flush),
    .stall_cycles_o  (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: a divide is tracked by its age in cycles since the
  // start pulse (0 = none); age DIV_LAT is the result cycle.
  // --------------------------------------------------------------------------
  bit m_valid  = 1'b0;
  bit m_first  = 1'b1;
  int m_age    = 0;
  bit m_signed = 1'b0;
  int m_cnt    = 0;

  function automatic void model_eval(output logic e_start, output logic e_cancel,
                                     output logic e_done, output logic e_flush,
                                     output logic [5:0] e_stall);
    bit act;
    bit haz;
    act = !rst && !m_first;
    haz = ex_is_load && ex_wreg && (ex_wd != 5'd0) &&
          ((id_reg1_read && id_reg1_addr == ex_wd) ||
           (id_reg2_read && id_reg2_addr == ex_wd));
    e_flush  = act && flush_req;
    e_start  = act && (m_age == 0) && ex_div_req && !flush_req;
    e_cancel = act && flush_req && (m_age != 0);
    e_done   = act && (m_age == DIV_LAT) && !flush_req;
    if (!act || flush_req)                          e_stall = 6'b000000;
    else if (e_start || (m_age >= 1 && m_age < DIV_LAT)) e_stall = 6'b001111;
    else if (m_age == DIV_LAT)                      e_stall = 6'b000000;
    else if (haz)                                   e_stall = 6'b000111;
    else                                            e_stall = 6'b000000;
  endfunction

  always @(posedge clk) begin
    logic s, c, d, f;
    logic [5:0] st;
    if (rst) begin
      m_valid = 1'b1; m_first = 1'b1; m_age = 0; m_signed = 1'b0; m_cnt = 0;
    end else begin
      model_eval(s, c, d, f, st);
      if (!m_first) begin
        if (flush_req)                 m_age = 0;
        else if (s) begin              m_age = 1; m_signed = ex_div_signed; end
        else if (m_age == DIV_LAT)     m_age = 0;
        else if (m_age > 0)            m_age = m_age + 1;
        if (st != 6'b0 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end
      m_first = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic s, c, d, f;
    logic [5:0] st;
    if (m_valid) begin
      model_eval(s, c, d, f, st);
      chk("m_div_start",    16'(div_start),    16'(s));
      chk("m_div_cancel",   16'(div_cancel),   16'(c));
      chk("m_div_done",     16'(div_done),     16'(d));
      chk("m_flush",        16'(flush),        16'(f));
      chk("m_stall",        16'(stall),        16'(st));
      chk("m_div_signed",   16'(div_signed),   16'(m_signed));
      chk("m_stall_cycles", 16'(stall_cycles), 16'(m_cnt));
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // --------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic clear_inputs();
    id_reg1_read = 1'b0; id_reg1_addr = 5'd0;
    id_reg2_read = 1'b0; id_reg2_addr = 5'd0;
    ex_is_load = 1'b0; ex_wd = 5'd0; ex_wreg = 1'b0;
    ex_div_req = 1'b0; ex_div_signed = 1'b0; flush_req = 1'b0;
  endtask

  task automatic set_hazard();
    ex_is_load = 1'b1; ex_wreg = 1'b1; ex_wd = 5'd5;
    id_reg1_read = 1'b1; id_reg1_addr = 5'd5;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    ex_div_req = 1'b1;
    cyc();

    // T1: reset held with a pending divide request.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_stall", 16'(stall), 16'h0);
      chk("t1_div_start", 16'(div_start), 16'h0);
      chk("t1_stall_cycles", 16'(stall_cycles), 16'h0);
      cyc();
    end
    rst = 1'b0;
    @(negedge clk);
    chk("t1_first_div_start", 16'(div_start), 16'h0);
    chk("t1_first_stall", 16'(stall), 16'h0);
    cyc();
    ex_div_req = 1'b0;
    cyc();

    // T2: load-use hazards.
    do_reset();
    set_hazard();
    @(negedge clk);
    chk("t2_hazard_r1", 16'(stall), 16'h07);
    cyc();
    ex_wd = 5'd0; id_reg1_addr = 5'd0;
    @(negedge clk);
    chk("t2_r0_no_hazard", 16'(stall), 16'h00);
    cyc();
    id_reg1_read = 1'b0; id_reg2_read = 1'b1; id_reg2_addr = 5'd7; ex_wd = 5'd7;
    @(negedge clk);
    chk("t2_hazard_r2", 16'(stall), 16'h07);
    cyc();
    ex_wreg = 1'b0;
    @(negedge clk);
    chk("t2_no_wreg", 16'(stall), 16'h00);
    chk("t2_stall_cycles", 16'(stall_cycles), 16'h2);
    cyc();
    clear_inputs();

    // T3: signed divide, full latency.
    do_reset();
    ex_div_req = 1'b1; ex_div_signed = 1'b1;
    @(negedge clk);
    chk("t3_div_start", 16'(div_start), 16'h1);
    chk("t3_stall_c0", 16'(stall), 16'h0F);
    cyc();
    for (int i = 1; i < DIV_LAT; i++) begin
      @(negedge clk);
      chk("t3_stall_busy", 16'(stall), 16'h0F);
      chk("t3_no_restart", 16'(div_start), 16'h0);
      cyc();
    end
    @(negedge clk);
    chk("t3_div_done", 16'(div_done), 16'h1);
    chk("t3_stall_done", 16'(stall), 16'h00);
    chk("t3_div_signed", 16'(div_signed), 16'h1);
    chk("t3_stall_cycles", 16'(stall_cycles), 16'h4);
    cyc();
    ex_div_req = 1'b0;
    @(negedge clk);
    chk("t3_done_once", 16'(div_done), 16'h0);
    cyc();

    // T4: flush two cycles after div_start, then an immediate unsigned divide.
    do_reset();
    ex_div_req = 1'b1; ex_div_signed = 1'b1;
    cyc();
    cyc();
    flush_req = 1'b1;
    @(negedge clk);
    chk("t4_flush", 16'(flush), 16'h1);
    chk("t4_div_cancel", 16'(div_cancel), 16'h1);
    chk("t4_stall", 16'(stall), 16'h00);
    cyc();
    flush_req = 1'b0; ex_div_signed = 1'b0;
    @(negedge clk);
    chk("t4_idle_restart", 16'(div_start), 16'h1);
    chk("t4_no_done", 16'(div_done), 16'h0);
    cyc();
    @(negedge clk);
    chk("t4_divu_signed", 16'(div_signed), 16'h0);
    for (int i = 0; i < DIV_LAT; i++) cyc();
    ex_div_req = 1'b0;
    cyc();

    // T5: hazard + divide together, reset mid-divide, flush + request.
    do_reset();
    set_hazard();
    ex_div_req = 1'b1;
    @(negedge clk);
    chk("t5_stall_both", 16'(stall), 16'h0F);
    chk("t5_div_start", 16'(div_start), 16'h1);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_no_cancel", 16'(div_cancel), 16'h0);
    cyc();
    rst = 1'b0;
    cyc();
    flush_req = 1'b1;
    @(negedge clk);
    chk("t5_flush_no_start", 16'(div_start), 16'h0);
    chk("t5_flush_stall", 16'(stall), 16'h00);
    cyc();
    clear_inputs();
    cyc();

    // T6: counter saturation.
    do_reset();
    set_hazard();
    for (int i = 0; i < 20; i++) cyc();
    @(negedge clk);
    chk("t6_stall", 16'(stall), 16'h07);
    chk("t6_saturated", 16'(stall_cycles), 16'hF);
    cyc();
    clear_inputs();
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
